cpu_mem_loader: RTL and testbench

//  Host-side driver for the CPU external memory ports. Consumes a 64-bit valid/ready command

---
 rtl/cpu_mem_loader_if.sv | 34 +++
 rtl/cpu_mem_loader.sv | 197 +++++++++++++++++++
 tb/tb_cpu_mem_loader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_loader_if.sv
// Bundle of the command/dump streams and the CPU external memory ports driven by cpu_mem_loader.
// Streams: a word moves on any rising clk edge where valid && ready; the source holds valid and data stable until then.
interface cpu_mem_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;

  modport master (
    input  in_valid, in_data, out_ready, rdata_ext, rdata_ext_2,
    output in_ready, out_valid, out_data,
    output addr_ext, wen_ext, ren_ext, wdata_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );

  modport slave (
    output in_valid, in_data, out_ready, rdata_ext, rdata_ext_2,
    input  in_ready, out_valid, out_data,
    input  addr_ext, wen_ext, ren_ext, wdata_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );
endinterface

// File: rtl/cpu_mem_loader.sv
// Host-side loader: preloads IMEM/DMEM from a 64-bit command stream, gates cpu_enable,
// and streams DMEM words back out. All ext-port outputs are registered.
module cpu_mem_loader #(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    arst,
  cpu_mem_loader_if.master        bus,
  output logic                    busy,
  output logic                    cpu_enable,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_I  = 3'd1,
    S_LOAD_D  = 3'd2,
    S_RUN     = 3'd3,
    S_RD_REQ  = 3'd4,
    S_RD_WAIT = 3'd5,
    S_OUT     = 3'd6
  } state_t;

  localparam logic [1:0]       LAT     = 2'(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_n;
  logic [15:0]        ptr_q, ptr_n;
  logic [CNT_W-1:0]   rem_q, rem_n;
  logic [1:0]         wcnt_q, wcnt_n;
  logic               armed_q;
  logic               en_q, en_n;
  logic               ov_q, ov_n;
  logic [63:0]        od_q, od_n;
  logic [63:0]        a1_q, a1_n;
  logic               w1_q, w1_n;
  logic [31:0]        d1_q, d1_n;
  logic [63:0]        a2_q, a2_n;
  logic               w2_q, w2_n;
  logic               r2_q, r2_n;
  logic [63:0]        d2_q, d2_n;

  logic               in_ready;
  logic               accept;
  logic [1:0]         hdr_op;
  logic [CNT_W-1:0]   hdr_cnt;
  logic               last;
  logic               unused_rdata;

  // armed_q keeps in_ready low while reset is held and for the first cycle after release.
  assign in_ready = armed_q &&
                    (state_q == S_IDLE || state_q == S_LOAD_I || state_q == S_LOAD_D);
  assign accept   = bus.in_valid && in_ready;
  assign hdr_op   = bus.in_data[63:62];
  assign hdr_cnt  = bus.in_data[CNT_W-1:0];
  assign last     = (rem_q == CNT_ONE);
  assign unused_rdata = ^bus.rdata_ext;

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    rem_n   = rem_q;
    wcnt_n  = wcnt_q;
    en_n    = en_q;
    ov_n    = ov_q;
    od_n    = od_q;
    a1_n    = a1_q;
    w1_n    = 1'b0;
    d1_n    = d1_q;
    a2_n    = a2_q;
    w2_n    = 1'b0;
    r2_n    = 1'b0;
    d2_n    = d2_q;
    case (state_q)
      S_IDLE: begin
        if (accept && hdr_cnt != '0) begin
          ptr_n = bus.in_data[47:32];
          rem_n = hdr_cnt;
          case (hdr_op)
            2'd0: state_n = S_LOAD_I;
            2'd1: state_n = S_LOAD_D;
            2'd2: begin
              state_n = S_RUN;
              en_n    = 1'b1;
            end
            default: state_n = S_RD_REQ;
          endcase
        end
      end
      S_LOAD_I: begin
        if (accept) begin
          w1_n  = 1'b1;
          a1_n  = {46'd0, ptr_q, 2'b00};
          d1_n  = bus.in_data[31:0];
          ptr_n = ptr_q + 16'd1;
          rem_n = rem_q - CNT_ONE;
          if (last) state_n = S_IDLE;
        end
      end
      S_LOAD_D: begin
        if (accept) begin
          w2_n  = 1'b1;
          a2_n  = {45'd0, ptr_q, 3'b000};
          d2_n  = bus.in_data;
          ptr_n = ptr_q + 16'd1;
          rem_n = rem_q - CNT_ONE;
          if (last) state_n = S_IDLE;
        end
      end
      S_RUN: begin
        rem_n = rem_q - CNT_ONE;
        if (last) begin
          en_n    = 1'b0;
          state_n = S_IDLE;
        end
      end
      S_RD_REQ: begin
        r2_n    = 1'b1;
        a2_n    = {45'd0, ptr_q, 3'b000};
        wcnt_n  = 2'd0;
        state_n = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // wcnt counts cycles since ren_ext_2 went high; data is valid once it reaches RD_LAT.
        if (wcnt_q == LAT) begin
          od_n    = bus.rdata_ext_2;
          ov_n    = 1'b1;
          state_n = S_OUT;
        end else begin
          wcnt_n = wcnt_q + 2'd1;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          ov_n    = 1'b0;
          ptr_n   = ptr_q + 16'd1;
          rem_n   = rem_q - CNT_ONE;
          state_n = last ? S_IDLE : S_RD_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      wcnt_q  <= '0;
      armed_q <= 1'b0;
      en_q    <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      a1_q    <= '0;
      w1_q    <= 1'b0;
      d1_q    <= '0;
      a2_q    <= '0;
      w2_q    <= 1'b0;
      r2_q    <= 1'b0;
      d2_q    <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      rem_q   <= rem_n;
      wcnt_q  <= wcnt_n;
      armed_q <= 1'b1;
      en_q    <= en_n;
      ov_q    <= ov_n;
      od_q    <= od_n;
      a1_q    <= a1_n;
      w1_q    <= w1_n;
      d1_q    <= d1_n;
      a2_q    <= a2_n;
      w2_q    <= w2_n;
      r2_q    <= r2_n;
      d2_q    <= d2_n;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = ov_q;
  assign bus.out_data    = od_q;
  assign bus.addr_ext    = a1_q;
  assign bus.wen_ext     = w1_q;
  assign bus.ren_ext     = 1'b0;
  assign bus.wdata_ext   = d1_q;
  assign bus.addr_ext_2  = a2_q;
  assign bus.wen_ext_2   = w2_q;
  assign bus.ren_ext_2   = r2_q;
  assign bus.wdata_ext_2 = d2_q;
  assign busy            = (state_q != S_IDLE);
  assign cpu_enable      = en_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Directed bench for cpu_mem_loader: an ext-port access monitor against an expected queue,
// a DMEM model with one cycle read latency, and explicit stream/enable checks.
module tb_cpu_mem_loader;
  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       busy;
  logic       cpu_enable;
  logic [2:0] state_dbg;

  cpu_mem_loader_if bus ();

  cpu_mem_loader #(.RD_LAT(1), .CNT_W(16)) dut (
    .clk        (clk),
    .arst       (arst),
    .bus        (bus),
    .busy       (busy),
    .cpu_enable (cpu_enable),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int overlap  = 0;
  int ren_i    = 0;
  logic [129:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input logic [1:0] op, input logic [15:0] base,
                                      input logic [15:0] cnt);
    return {op, 14'd0, base, 16'd0, cnt};
  endfunction

  // DMEM model: read data appears the cycle after ren_ext_2 is seen.
  logic [63:0] dmem [logic [63:0]];
  assign bus.rdata_ext = 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (bus.wen_ext_2) dmem[bus.addr_ext_2] = bus.wdata_ext_2;
    if (bus.ren_ext_2)
      bus.rdata_ext_2 <= dmem.exists(bus.addr_ext_2) ? dmem[bus.addr_ext_2] : 64'd0;
  end

  // Access monitor: kind 0 = IMEM write, 1 = DMEM write, 2 = DMEM read.
  int           n_str;
  logic [1:0]   m_kind;
  logic [63:0]  m_addr, m_data;
  logic [129:0] m_exp;
  always @(negedge clk) begin
    if (!arst) begin
      n_str = int'(bus.wen_ext) + int'(bus.wen_ext_2) + int'(bus.ren_ext_2);
      if (n_str > 1) overlap++;
      if (bus.ren_ext) ren_i++;
      if (n_str != 0) begin
        if (bus.wen_ext) begin
          m_kind = 2'd0; m_addr = bus.addr_ext; m_data = {32'd0, bus.wdata_ext};
        end else if (bus.wen_ext_2) begin
          m_kind = 2'd1; m_addr = bus.addr_ext_2; m_data = bus.wdata_ext_2;
        end else begin
          m_kind = 2'd2; m_addr = bus.addr_ext_2; m_data = 64'd0;
        end
        if (exp_q.size() == 0) begin
          check("extra_access", {62'd0, m_kind}, 64'hFFFF);
        end else begin
          m_exp = exp_q.pop_front();
          check("acc_kind", {62'd0, m_kind}, {62'd0, m_exp[129:128]});
          check("acc_addr", m_addr, m_exp[127:64]);
          if (m_kind != 2'd2) check("acc_data", m_data, m_exp[63:0]);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [63:0] w, input bit hold = 1'b0);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("send_timeout", 64'd1, 64'd0);
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("out_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt, busy_cnt, rdy_bad;
    bus.in_valid  = 1'b0;
    bus.in_data   = 64'd0;
    bus.out_ready = 1'b0;

    // Reset state
    idle(2);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_enable", {63'd0, cpu_enable}, 64'd0);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_strobes", {60'd0, bus.wen_ext, bus.ren_ext, bus.wen_ext_2, bus.ren_ext_2}, 64'd0);
    check("rst_addrs", bus.addr_ext | bus.addr_ext_2, 64'd0);
    check("rst_wdata", {32'd0, bus.wdata_ext} | bus.wdata_ext_2, 64'd0);
    check("rst_state", {61'd0, state_dbg}, 64'd0);
    arst = 1'b0;

    // T2: IMEM load with a gap and a back-to-back pair; upper data bits dropped
    exp_q.push_back({2'd0, 64'd8,  64'h0000_0000_AAAA_0001});
    exp_q.push_back({2'd0, 64'd12, 64'h0000_0000_BBBB_0002});
    exp_q.push_back({2'd0, 64'd16, 64'h0000_0000_CCCC_0003});
    send(hdr(2'd0, 16'd2, 16'd3));
    check("t2_busy", {63'd0, busy}, 64'd1);
    send(64'hFFFF_0000_AAAA_0001);
    bus.in_data = 64'h1234_5678_9ABC_DEF0;
    idle(3);
    send(64'h1111_2222_BBBB_0002, 1'b1);
    send(64'h3333_4444_CCCC_0003);
    idle(2);
    check("t2_idle", {63'd0, busy}, 64'd0);
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // T1: reset in the middle of an IMEM load, then a fresh load
    exp_q.push_back({2'd0, 64'h40, 64'h0000_0000_5555_0001});
    send(hdr(2'd0, 16'h10, 16'd4));
    send(64'h0000_0000_5555_0001);
    idle(1);
    arst = 1'b1;
    #1;
    check("t1_busy", {63'd0, busy}, 64'd0);
    check("t1_addr", bus.addr_ext, 64'd0);
    check("t1_in_ready", {63'd0, bus.in_ready}, 64'd0);
    idle(2);
    arst = 1'b0;
    exp_q.push_back({2'd0, 64'h80, 64'h0000_0000_7777_0009});
    send(hdr(2'd0, 16'h20, 16'd1));
    send(64'h0000_0000_7777_0009);
    idle(2);
    check("t1_idle", {63'd0, busy}, 64'd0);

    // count 0 header is a no-op
    send(hdr(2'd0, 16'd5, 16'd0));
    check("nop_busy", {63'd0, busy}, 64'd0);
    idle(3);

    // T3: DMEM load then dump with out_ready stalled
    exp_q.push_back({2'd1, 64'd0, 64'hD000_0000_0000_00D0});
    exp_q.push_back({2'd1, 64'd8, 64'hD111_0000_0000_00D1});
    send(hdr(2'd1, 16'd0, 16'd2));
    send(64'hD000_0000_0000_00D0);
    send(64'hD111_0000_0000_00D1);
    idle(2);
    exp_q.push_back({2'd2, 64'd0, 64'd0});
    exp_q.push_back({2'd2, 64'd8, 64'd0});
    send(hdr(2'd3, 16'd0, 16'd2));
    check("t3_in_ready", {63'd0, bus.in_ready}, 64'd0);
    wait_out();
    check("t3_d0", bus.out_data, 64'hD000_0000_0000_00D0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", {63'd0, bus.out_valid}, 64'd1);
      check("t3_hold_data", bus.out_data, 64'hD000_0000_0000_00D0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t3_busy_mid", {63'd0, busy}, 64'd1);
    wait_out();
    check("t3_d1", bus.out_data, 64'hD111_0000_0000_00D1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t3_busy_end", {63'd0, busy}, 64'd0);
    check("t3_valid_end", {63'd0, bus.out_valid}, 64'd0);

    // T4: RUN for 10 cycles, then RUN with count 0
    send(hdr(2'd2, 16'd0, 16'd10));
    check("t4_start", {63'd0, cpu_enable}, 64'd1);
    en_cnt = 0; busy_cnt = 0; rdy_bad = 0;
    for (int i = 0; i < 20; i++) begin
      en_cnt   += int'(cpu_enable);
      busy_cnt += int'(busy);
      if (cpu_enable && bus.in_ready) rdy_bad++;
      @(negedge clk);
    end
    check("t4_en_cycles", 64'(en_cnt), 64'd10);
    check("t4_busy_cycles", 64'(busy_cnt), 64'd10);
    check("t4_ready_in_run", 64'(rdy_bad), 64'd0);
    send(hdr(2'd2, 16'd0, 16'd0));
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      en_cnt += int'(cpu_enable);
      @(negedge clk);
    end
    check("t4_zero_en", 64'(en_cnt), 64'd0);

    // T5: pointer wrap at 0xFFFF on load and dump
    exp_q.push_back({2'd1, 64'h7FFF8, 64'hE0E0_0000_0000_0001});
    exp_q.push_back({2'd1, 64'h0,     64'hE1E1_0000_0000_0002});
    send(hdr(2'd1, 16'hFFFF, 16'd2));
    send(64'hE0E0_0000_0000_0001, 1'b1);
    send(64'hE1E1_0000_0000_0002);
    idle(2);
    exp_q.push_back({2'd2, 64'h7FFF8, 64'd0});
    exp_q.push_back({2'd2, 64'h0,     64'd0});
    bus.out_ready = 1'b1;
    send(hdr(2'd3, 16'hFFFF, 16'd2));
    wait_out();
    check("t5_w0", bus.out_data, 64'hE0E0_0000_0000_0001);
    @(negedge clk);
    wait_out();
    check("t5_w1", bus.out_data, 64'hE1E1_0000_0000_0002);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t5_busy_end", {63'd0, busy}, 64'd0);
    idle(3);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("strobe_overlap", 64'(overlap), 64'd0);
    check("imem_ren_seen", 64'(ren_i), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
